// File: rtl/admodel_neuron_array.sv
// Time-multiplexed array of N amyloid-beta SDSP neurons with per-neuron membrane,
// calcium and calcium-leak counter storage, SDSP reporting and calcium-dependent bursts.
module admodel_neuron_array #(
  parameter int N         = 16,
  parameter int MEM_W     = 8,
  parameter int W_W       = 3,
  parameter int BURST_MAX = 3,
  localparam int AW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             param_a,
  input  logic [3:0]       param_p,
  input  logic [MEM_W-2:0] param_leak_str,
  input  logic             param_leak_en,
  input  logic [MEM_W-1:0] param_thr,
  input  logic             param_ca_en,
  input  logic [MEM_W-1:0] param_thetamem,
  input  logic [2:0]       param_ca_theta1,
  input  logic [2:0]       param_ca_theta2,
  input  logic [2:0]       param_ca_theta3,
  input  logic [4:0]       param_caleak,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [AW-1:0]    ev_addr,
  input  logic             ev_tref,
  input  logic [W_W-1:0]   ev_weight,
  input  logic             ev_sign,
  output logic             sdsp_valid,
  output logic             v_up,
  output logic             v_down,
  output logic             spk_valid,
  input  logic             spk_ready,
  output logic [AW-1:0]    spk_addr,
  output logic [1:0]       spk_idx
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_UPD = 2'd1, S_EMIT = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             tref_q, tref_d;
  logic [W_W-1:0]   weight_q, weight_d;
  logic             sign_q, sign_d;
  logic [1:0]       k_q, k_d;
  logic             ev_ready_q, ev_ready_d;
  logic             sdsp_valid_q, sdsp_valid_d;
  logic             v_up_q, v_up_d;
  logic             v_down_q, v_down_d;
  logic             spk_valid_q, spk_valid_d;
  logic [AW-1:0]    spk_addr_q, spk_addr_d;
  logic [1:0]       spk_idx_q, spk_idx_d;

  logic [MEM_W-1:0] mem_q [N];
  logic [2:0]       ca_q  [N];
  logic [5:0]       cnt_q [N];

  logic             addr_ok_s;
  logic [AW-1:0]    idx_s;
  logic [MEM_W-1:0] cur_mem_s, leak_ext_s, w_ext_s, leak_mem_s, syn_mem_s;
  logic [2:0]       cur_ca_s, inc_s, ca_fire_s, ca_leak_s;
  logic [5:0]       cur_cnt_s, cnt_inc_s, period_s;
  logic             cal_dec_s, fire_s, up_s, down_s;
  logic [MEM_W:0]   sum_s;
  logic [3:0]       ca_sum_s;
  logic [1:0]       burst_raw_s, burst_s;
  logic             wr_en_s;
  logic [MEM_W-1:0] wr_mem_s;
  logic [2:0]       wr_ca_s;
  logic [5:0]       wr_cnt_s;

  // Datapath: next-state candidates for the addressed neuron from its pre-update state.
  always_comb begin
    addr_ok_s = (int'(addr_q) < N);
    if (addr_ok_s) idx_s = addr_q;
    else           idx_s = '0;
    cur_mem_s  = mem_q[idx_s];
    cur_ca_s   = ca_q[idx_s];
    cur_cnt_s  = cnt_q[idx_s];
    leak_ext_s = {1'b0, param_leak_str};
    w_ext_s    = {{(MEM_W-W_W){1'b0}}, weight_q};

    if (!param_leak_en)              leak_mem_s = cur_mem_s;
    else if (cur_mem_s > leak_ext_s) leak_mem_s = cur_mem_s - leak_ext_s;
    else                             leak_mem_s = '0;

    // Amyloid-beta stretches the calcium leak period by param_p.
    cnt_inc_s = cur_cnt_s + 6'd1;
    if (param_a) period_s = {1'b0, param_caleak} + {2'b00, param_p};
    else         period_s = {1'b0, param_caleak};
    cal_dec_s = (param_caleak != 5'd0) && (cnt_inc_s >= period_s);
    if (cur_ca_s != 3'd0) ca_leak_s = cur_ca_s - 3'd1;
    else                  ca_leak_s = 3'd0;

    sum_s = {1'b0, cur_mem_s} + {1'b0, w_ext_s};
    if (sign_q) begin
      if (cur_mem_s >= w_ext_s) syn_mem_s = cur_mem_s - w_ext_s;
      else                      syn_mem_s = '0;
    end else begin
      if (sum_s[MEM_W]) syn_mem_s = '1;
      else              syn_mem_s = sum_s[MEM_W-1:0];
    end
    fire_s = !sign_q && (syn_mem_s >= param_thr);

    if (param_a) inc_s = 3'd1 + {1'b0, param_p[1:0]};
    else         inc_s = 3'd1;
    ca_sum_s = {1'b0, cur_ca_s} + {1'b0, inc_s};
    if (!param_ca_en)     ca_fire_s = cur_ca_s;
    else if (ca_sum_s[3]) ca_fire_s = 3'd7;
    else                  ca_fire_s = ca_sum_s[2:0];

    burst_raw_s = 2'd1 + {1'b0, param_a && (ca_fire_s >= param_ca_theta2)}
                       + {1'b0, param_a && (ca_fire_s >= param_ca_theta3)};
    if (burst_raw_s > 2'(BURST_MAX)) burst_s = 2'(BURST_MAX);
    else                             burst_s = burst_raw_s;

    up_s   = param_ca_en && (cur_mem_s >= param_thetamem) &&
             (cur_ca_s >= param_ca_theta1) && (cur_ca_s < param_ca_theta3);
    down_s = param_ca_en && (cur_mem_s < param_thetamem) &&
             (cur_ca_s >= param_ca_theta1) && (cur_ca_s < param_ca_theta2);
  end

  // Control: IDLE/UPD/EMIT sequencing, registered outputs and the state-store write strobe.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    tref_d       = tref_q;
    weight_d     = weight_q;
    sign_d       = sign_q;
    k_d          = k_q;
    ev_ready_d   = ev_ready_q;
    sdsp_valid_d = 1'b0;
    v_up_d       = 1'b0;
    v_down_d     = 1'b0;
    spk_valid_d  = spk_valid_q;
    spk_addr_d   = spk_addr_q;
    spk_idx_d    = spk_idx_q;
    wr_en_s      = 1'b0;
    wr_mem_s     = cur_mem_s;
    wr_ca_s      = cur_ca_s;
    wr_cnt_s     = cur_cnt_s;
    case (state_q)
      S_IDLE: begin
        if (ev_valid) begin
          addr_d     = ev_addr;
          tref_d     = ev_tref;
          weight_d   = ev_weight;
          sign_d     = ev_sign;
          ev_ready_d = 1'b0;
          state_d    = S_UPD;
        end else begin
          ev_ready_d = 1'b1;
        end
      end
      S_UPD: begin
        if (!addr_ok_s) begin
          state_d    = S_IDLE;
          ev_ready_d = 1'b1;
        end else if (tref_q) begin
          wr_en_s    = 1'b1;
          wr_mem_s   = leak_mem_s;
          wr_cnt_s   = cal_dec_s ? 6'd0 : cnt_inc_s;
          wr_ca_s    = cal_dec_s ? ca_leak_s : cur_ca_s;
          state_d    = S_IDLE;
          ev_ready_d = 1'b1;
        end else begin
          wr_en_s      = 1'b1;
          sdsp_valid_d = 1'b1;
          v_up_d       = up_s;
          v_down_d     = down_s;
          if (fire_s) begin
            wr_mem_s    = '0;
            wr_ca_s     = ca_fire_s;
            k_d         = burst_s;
            spk_valid_d = 1'b1;
            spk_addr_d  = addr_q;
            spk_idx_d   = 2'd0;
            state_d     = S_EMIT;
          end else begin
            wr_mem_s   = syn_mem_s;
            state_d    = S_IDLE;
            ev_ready_d = 1'b1;
          end
        end
      end
      S_EMIT: begin
        if (!spk_ready) begin
          spk_valid_d = 1'b1;
        end else if (spk_idx_q == (k_q - 2'd1)) begin
          spk_valid_d = 1'b0;
          ev_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end else begin
          spk_idx_d = spk_idx_q + 2'd1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        ev_ready_d  = 1'b1;
        spk_valid_d = 1'b0;
      end
    endcase
  end

  // State registers and per-neuron storage, cleared by synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      tref_q       <= 1'b0;
      weight_q     <= '0;
      sign_q       <= 1'b0;
      k_q          <= 2'd0;
      ev_ready_q   <= 1'b1;
      sdsp_valid_q <= 1'b0;
      v_up_q       <= 1'b0;
      v_down_q     <= 1'b0;
      spk_valid_q  <= 1'b0;
      spk_addr_q   <= '0;
      spk_idx_q    <= 2'd0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
        ca_q[i]  <= 3'd0;
        cnt_q[i] <= 6'd0;
      end
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      tref_q       <= tref_d;
      weight_q     <= weight_d;
      sign_q       <= sign_d;
      k_q          <= k_d;
      ev_ready_q   <= ev_ready_d;
      sdsp_valid_q <= sdsp_valid_d;
      v_up_q       <= v_up_d;
      v_down_q     <= v_down_d;
      spk_valid_q  <= spk_valid_d;
      spk_addr_q   <= spk_addr_d;
      spk_idx_q    <= spk_idx_d;
      if (wr_en_s) begin
        mem_q[idx_s] <= wr_mem_s;
        ca_q[idx_s]  <= wr_ca_s;
        cnt_q[idx_s] <= wr_cnt_s;
      end
    end
  end

  assign ev_ready   = ev_ready_q;
  assign sdsp_valid = sdsp_valid_q;
  assign v_up       = v_up_q;
  assign v_down     = v_down_q;
  assign spk_valid  = spk_valid_q;
  assign spk_addr   = spk_addr_q;
  assign spk_idx    = spk_idx_q;

endmodule

// File: tb/tb_admodel_neuron_array.sv
// Bench for admodel_neuron_array: directed scenarios plus randomized events checked
// against an arithmetic per-neuron reference model.
module tb_admodel_neuron_array;
  localparam int N = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RSTN;
  logic       p_a, p_leak_en, p_ca_en;
  logic [3:0] p_p;
  logic [6:0] p_leak_str;
  logic [7:0] p_thr, p_thetamem;
  logic [2:0] p_th1, p_th2, p_th3;
  logic [4:0] p_caleak;

  logic       ev_valid, ev_ready, ev_tref, ev_sign;
  logic [3:0] ev_addr;
  logic [2:0] ev_weight;
  logic       sdsp_valid, v_up, v_down, spk_valid, spk_ready;
  logic [3:0] spk_addr;
  logic [1:0] spk_idx;

  logic       ev_valid2, ev_ready2, ev_tref2, ev_sign2;
  logic [3:0] ev_addr2;
  logic [2:0] ev_weight2;
  logic       sdsp_valid2, v_up2, v_down2, spk_valid2, spk_ready2;
  logic [3:0] spk_addr2;
  logic [1:0] spk_idx2;

  int checks = 0;
  int failures = 0;
  int m_mem [N];
  int m_ca  [N];
  int m_cnt [N];

  admodel_neuron_array #(.N(16)) u_dut (
    .CLK(CLK), .RSTN(RSTN), .param_a(p_a), .param_p(p_p), .param_leak_str(p_leak_str),
    .param_leak_en(p_leak_en), .param_thr(p_thr), .param_ca_en(p_ca_en),
    .param_thetamem(p_thetamem), .param_ca_theta1(p_th1), .param_ca_theta2(p_th2),
    .param_ca_theta3(p_th3), .param_caleak(p_caleak), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_addr(ev_addr), .ev_tref(ev_tref), .ev_weight(ev_weight),
    .ev_sign(ev_sign), .sdsp_valid(sdsp_valid), .v_up(v_up), .v_down(v_down),
    .spk_valid(spk_valid), .spk_ready(spk_ready), .spk_addr(spk_addr), .spk_idx(spk_idx)
  );

  // Twelve-neuron instance so that out-of-range addresses are representable.
  admodel_neuron_array #(.N(12)) u_dut12 (
    .CLK(CLK), .RSTN(RSTN), .param_a(p_a), .param_p(p_p), .param_leak_str(p_leak_str),
    .param_leak_en(p_leak_en), .param_thr(p_thr), .param_ca_en(p_ca_en),
    .param_thetamem(p_thetamem), .param_ca_theta1(p_th1), .param_ca_theta2(p_th2),
    .param_ca_theta3(p_th3), .param_caleak(p_caleak), .ev_valid(ev_valid2),
    .ev_ready(ev_ready2), .ev_addr(ev_addr2), .ev_tref(ev_tref2), .ev_weight(ev_weight2),
    .ev_sign(ev_sign2), .sdsp_valid(sdsp_valid2), .v_up(v_up2), .v_down(v_down2),
    .spk_valid(spk_valid2), .spk_ready(spk_ready2), .spk_addr(spk_addr2), .spk_idx(spk_idx2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0; m_ca[i] = 0; m_cnt[i] = 0;
    end
  endtask

  // Reference behaviour; returns {sdsp, up, down, k[2:0], err=0}.
  task automatic model_event(input int a, input bit t, input int w, input bit s,
                             output logic [6:0] ex);
    int mn, per, k;
    bit sd, up, dn;
    sd = 0; up = 0; dn = 0; k = 0;
    if (a < N) begin
      if (t) begin
        if (p_leak_en) m_mem[a] = (m_mem[a] > int'(p_leak_str)) ? m_mem[a] - int'(p_leak_str) : 0;
        m_cnt[a] = (m_cnt[a] + 1) % 64;
        per = int'(p_caleak) + (p_a ? int'(p_p) : 0);
        if (p_caleak != 0 && m_cnt[a] >= per) begin
          m_cnt[a] = 0;
          if (m_ca[a] > 0) m_ca[a] = m_ca[a] - 1;
        end
      end else begin
        sd = 1;
        up = p_ca_en && m_mem[a] >= int'(p_thetamem) && m_ca[a] >= int'(p_th1) && m_ca[a] < int'(p_th3);
        dn = p_ca_en && m_mem[a] <  int'(p_thetamem) && m_ca[a] >= int'(p_th1) && m_ca[a] < int'(p_th2);
        mn = s ? ((m_mem[a] > w) ? m_mem[a] - w : 0) : ((m_mem[a] + w > 255) ? 255 : m_mem[a] + w);
        if (!s && mn >= int'(p_thr)) begin
          m_mem[a] = 0;
          if (p_ca_en) begin
            m_ca[a] = m_ca[a] + (p_a ? 1 + (int'(p_p) % 4) : 1);
            if (m_ca[a] > 7) m_ca[a] = 7;
          end
          k = 1;
          if (p_a && m_ca[a] >= int'(p_th2)) k = k + 1;
          if (p_a && m_ca[a] >= int'(p_th3)) k = k + 1;
          if (k > 3) k = 3;
        end else begin
          m_mem[a] = mn;
        end
      end
    end
    ex = {sd, up, dn, 3'(k), 1'b0};
  endtask

  // Drives one event and observes {sdsp, up, down, tokens[2:0], protocol_error}.
  task automatic do_event(input logic [3:0] a, input bit t, input logic [2:0] w, input bit s,
                          input int hold_idx, input bit rnd_bp, output logic [6:0] obs);
    logic sd, up, dn, prev_stall, rdy, done;
    logic [3:0] pa;
    logic [1:0] pi;
    int ntok, held, g;
    bit err;
    err = 0; ntok = 0; held = 0; prev_stall = 0; done = 0; pa = '0; pi = '0; g = 0;
    while (!ev_ready && g < 20) begin
      @(posedge CLK); #1; g++;
    end
    if (!ev_ready) err = 1;
    ev_valid = 1'b1; ev_addr = a; ev_tref = t; ev_weight = w; ev_sign = s;
    @(posedge CLK); #1;
    ev_valid = 1'b0;
    @(posedge CLK); #1;
    sd = sdsp_valid; up = v_up; dn = v_down;
    for (int c = 0; c < 60 && !done; c++) begin
      if (c > 0 && sdsp_valid) err = 1;
      if (spk_valid) begin
        if (ev_ready) err = 1;
        if (spk_addr !== a || int'(spk_idx) != ntok) err = 1;
        if (prev_stall && (spk_addr !== pa || spk_idx !== pi)) err = 1;
        if (int'(spk_idx) == hold_idx && held < 5) begin
          rdy = 1'b0; held++;
        end else if (rnd_bp) begin
          rdy = 1'($urandom_range(0, 1));
        end else begin
          rdy = 1'b1;
        end
        spk_ready = rdy;
        if (rdy) ntok++;
        prev_stall = !rdy; pa = spk_addr; pi = spk_idx;
        @(posedge CLK); #1;
      end else begin
        if (prev_stall || !ev_ready) err = 1;
        done = 1;
      end
    end
    if (!done) err = 1;
    spk_ready = 1'b1;
    obs = {sd, up, dn, 3'((ntok > 7) ? 7 : ntok), err};
  endtask

  task automatic ev(input int a, input bit t, input int w, input bit s, input int hold,
                    input bit rnd, output logic [6:0] o, output logic [6:0] e);
    do_event(4'(a), t, 3'(w), s, hold, rnd, o);
    model_event(a, t, w, s, e);
  endtask

  task automatic apply_reset();
    ev_valid = 1'b0; ev_valid2 = 1'b0; spk_ready = 1'b1; spk_ready2 = 1'b1;
    RSTN = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1'b1;
    model_clear();
  endtask

  task automatic set_params(input bit a, input int p, input bit ca_en, input int thr,
                            input int thetamem, input int t1, input int t2, input int t3);
    p_a = a; p_p = 4'(p); p_ca_en = ca_en; p_thr = 8'(thr); p_thetamem = 8'(thetamem);
    p_th1 = 3'(t1); p_th2 = 3'(t2); p_th3 = 3'(t3);
    p_leak_en = 1'b0; p_leak_str = 7'd0; p_caleak = 5'd0;
  endtask

  task automatic test_reset();
    logic [6:0] o, e;
    logic [10:0] r;
    apply_reset();
    r = {ev_ready, sdsp_valid, v_up, v_down, spk_valid, spk_addr, spk_idx};
    checks++;
    if (r !== 11'b1_0000_0000_00) begin
      failures++; $display("FAIL reset_outputs got=%b want=%b", r, 11'b1_0000_0000_00);
    end
    set_params(1'b0, 0, 1'b0, 10, 128, 1, 2, 3);
    for (int i = 0; i < N; i++) begin
      ev(i, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
      checks++;
      if (o !== 7'b1000000) begin
        failures++; $display("FAIL reset_sweep n%0d got=%b want=%b", i, o, 7'b1000000);
      end
    end
  endtask

  task automatic test_single_spike();
    logic [6:0] o, e;
    apply_reset();
    set_params(1'b0, 0, 1'b1, 10, 128, 1, 2, 3);
    ev(5, 1'b0, 7, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1000000) begin
      failures++; $display("FAIL single_first got=%b want=%b", o, 7'b1000000);
    end
    ev(5, 1'b0, 7, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1000010) begin
      failures++; $display("FAIL single_spike got=%b want=%b", o, 7'b1000010);
    end
    p_thetamem = 8'd1;
    ev(5, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1010000) begin
      failures++; $display("FAIL single_probe_mem0_ca1 got=%b want=%b", o, 7'b1010000);
    end
  endtask

  task automatic test_burst();
    logic [6:0] o, e;
    apply_reset();
    set_params(1'b1, 3, 1'b1, 10, 128, 1, 2, 4);
    ev(3, 1'b0, 7, 1'b0, -1, 1'b0, o, e);
    ev(3, 1'b0, 7, 1'b0, 1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1000110) begin
      failures++; $display("FAIL burst_three_tokens got=%b want=%b", o, 7'b1000110);
    end
    p_thetamem = 8'd1; p_th1 = 3'd4; p_th2 = 3'd5; p_th3 = 3'd6;
    ev(3, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1010000) begin
      failures++; $display("FAIL burst_probe_ca4 got=%b want=%b", o, 7'b1010000);
    end
  endtask

  task automatic test_ca_leak();
    logic [6:0] o, e, want;
    apply_reset();
    set_params(1'b0, 0, 1'b1, 1, 1, 3, 4, 5);
    p_caleak = 5'd2;
    for (int i = 0; i < 4; i++) ev(2, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    for (int i = 1; i <= 2; i++) begin
      ev(2, 1'b1, 0, 1'b0, -1, 1'b0, o, e);
      checks++;
      if (o !== 7'b0000000) begin
        failures++; $display("FAIL leak_tref_quiet got=%b want=%b", o, 7'b0000000);
      end
      ev(2, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
      want = (i == 2) ? 7'b1010000 : 7'b1000000;
      checks++;
      if (o !== want) begin
        failures++; $display("FAIL leak_a0_tref%0d got=%b want=%b", i, o, want);
      end
    end
    for (int i = 0; i < 4; i++) ev(7, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    p_a = 1'b1; p_p = 4'd2;
    for (int i = 1; i <= 4; i++) begin
      ev(7, 1'b1, 0, 1'b0, -1, 1'b0, o, e);
      ev(7, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
      want = (i == 4) ? 7'b1010000 : 7'b1000000;
      checks++;
      if (o !== want) begin
        failures++; $display("FAIL leak_a1_tref%0d got=%b want=%b", i, o, want);
      end
    end
  endtask

  task automatic test_saturation();
    logic [6:0] o, e;
    apply_reset();
    set_params(1'b0, 0, 1'b1, 255, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) ev(9, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    ev(9, 1'b0, 7, 1'b1, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1100000) begin
      failures++; $display("FAIL sat_inhib_pre got=%b want=%b", o, 7'b1100000);
    end
    ev(9, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1010000) begin
      failures++; $display("FAIL sat_inhib_floor got=%b want=%b", o, 7'b1010000);
    end
    ev(10, 1'b0, 5, 1'b0, -1, 1'b0, o, e);
    p_leak_en = 1'b1; p_leak_str = 7'd20;
    ev(10, 1'b1, 0, 1'b0, -1, 1'b0, o, e);
    p_leak_en = 1'b0;
    ev(10, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1010000) begin
      failures++; $display("FAIL sat_leak_floor got=%b want=%b", o, 7'b1010000);
    end
    set_params(1'b1, 0, 1'b1, 1, 1, 0, 7, 7);
    for (int i = 0; i < 7; i++) ev(11, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    ev(11, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1000110) begin
      failures++; $display("FAIL sat_ca7_spike got=%b want=%b", o, 7'b1000110);
    end
  endtask

  task automatic test_sdsp();
    logic [6:0] o, e;
    apply_reset();
    set_params(1'b0, 0, 1'b1, 1, 128, 1, 3, 5);
    for (int i = 0; i < 2; i++) ev(13, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    for (int i = 0; i < 2; i++) ev(14, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    p_thr = 8'd255;
    for (int i = 0; i < 28; i++) ev(13, 1'b0, 7, 1'b0, -1, 1'b0, o, e);
    ev(13, 1'b0, 4, 1'b0, -1, 1'b0, o, e);
    ev(13, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1100000) begin
      failures++; $display("FAIL sdsp_up got=%b want=%b", o, 7'b1100000);
    end
    for (int i = 0; i < 7; i++) ev(14, 1'b0, 7, 1'b0, -1, 1'b0, o, e);
    ev(14, 1'b0, 1, 1'b0, -1, 1'b0, o, e);
    ev(14, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1010000) begin
      failures++; $display("FAIL sdsp_down got=%b want=%b", o, 7'b1010000);
    end
  endtask

  task automatic test_out_of_range();
    logic [2:0] r, want;
    int g;
    set_params(1'b0, 0, 1'b1, 1, 1, 0, 1, 1);
    for (int a = 11; a < 16; a++) begin
      g = 0;
      while (!ev_ready2 && g < 20) begin
        @(posedge CLK); #1; g++;
      end
      ev_valid2 = 1'b1; ev_addr2 = 4'(a); ev_tref2 = 1'b0; ev_weight2 = 3'd7; ev_sign2 = 1'b0;
      @(posedge CLK); #1;
      ev_valid2 = 1'b0;
      @(posedge CLK); #1;
      r = {sdsp_valid2, spk_valid2, ev_ready2};
      want = (a == 11) ? 3'b110 : 3'b001;
      checks++;
      if (r !== want) begin
        failures++; $display("FAIL oor_addr%0d got=%b want=%b", a, r, want);
      end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] o, e;
    logic [10:0] r;
    logic stray;
    apply_reset();
    set_params(1'b1, 3, 1'b1, 1, 1, 0, 2, 4);
    ev_valid = 1'b1; ev_addr = 4'd6; ev_tref = 1'b0; ev_weight = 3'd7; ev_sign = 1'b0;
    @(posedge CLK); #1;
    ev_valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if ({spk_valid, spk_idx} !== 3'b101) begin
      failures++; $display("FAIL midburst_second_token got=%b want=%b", {spk_valid, spk_idx}, 3'b101);
    end
    RSTN = 1'b0;
    @(posedge CLK); #1;
    RSTN = 1'b1;
    model_clear();
    r = {ev_ready, sdsp_valid, v_up, v_down, spk_valid, spk_addr, spk_idx};
    checks++;
    if (r !== 11'b1_0000_0000_00) begin
      failures++; $display("FAIL midburst_reset_outputs got=%b want=%b", r, 11'b1_0000_0000_00);
    end
    stray = 1'b0;
    repeat (4) begin
      @(posedge CLK); #1;
      if (spk_valid) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      failures++; $display("FAIL midburst_stray_token got=%b want=0", stray);
    end
    ev(6, 1'b0, 0, 1'b0, -1, 1'b0, o, e);
    checks++;
    if (o !== 7'b1010000) begin
      failures++; $display("FAIL midburst_state_cleared got=%b want=%b", o, 7'b1010000);
    end
  endtask

  task automatic test_random();
    logic [6:0] o, e;
    int a, w;
    bit t, s;
    for (int n = 0; n < 400; n++) begin
      if (n % 25 == 0) begin
        p_a = 1'($urandom_range(0, 1)); p_p = 4'($urandom_range(0, 15));
        p_leak_en = 1'($urandom_range(0, 1)); p_leak_str = 7'($urandom_range(0, 10));
        p_thr = 8'($urandom_range(0, 30)); p_ca_en = ($urandom_range(0, 3) != 0);
        p_thetamem = 8'($urandom_range(0, 30)); p_caleak = 5'($urandom_range(0, 6));
        p_th1 = 3'($urandom_range(0, 7)); p_th2 = 3'($urandom_range(0, 7));
        p_th3 = 3'($urandom_range(0, 7));
      end
      a = $urandom_range(0, N - 1);
      t = ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 7);
      s = ($urandom_range(0, 3) == 0);
      ev(a, t, w, s, -1, 1'b1, o, e);
      checks++;
      if (o !== e) begin
        failures++; $display("FAIL random ev%0d addr=%0d tref=%0d got=%b want=%b", n, a, t, o, e);
      end
    end
  endtask

  initial begin
    RSTN = 1'b0; ev_valid = 1'b0; ev_addr = '0; ev_tref = 1'b0; ev_weight = '0; ev_sign = 1'b0;
    ev_valid2 = 1'b0; ev_addr2 = '0; ev_tref2 = 1'b0; ev_weight2 = '0; ev_sign2 = 1'b0;
    spk_ready = 1'b1; spk_ready2 = 1'b1;
    set_params(1'b0, 0, 1'b0, 10, 128, 1, 2, 3);
    @(posedge CLK); #1;
    test_reset();
    test_single_spike();
    test_burst();
    test_ca_leak();
    test_saturation();
    test_sdsp();
    test_out_of_range();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
